// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if -- operand/result bundle between the multdiv wrapper and the
// signed restoring divider.
//
//   data_operandA   dividend, two's complement, sampled on ctrl_DIV
//   data_operandB   divisor, two's complement, sampled on ctrl_DIV
//   ctrl_DIV        start strobe (also aborts and restarts a running divide)
//   data_result     quotient truncated toward zero, held until the next result
//   data_exception  divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY  one-cycle pulse: result and exception valid
//   busy            high while the divider iterates
//
// master: the requester (wrapper / testbench); slave: the divider.
// ---------------------------------------------------------------------------
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle signed integer divider.
//
// A start strobe latches |A|, |B| and the quotient sign, then a restoring
// shift-subtract loop produces one quotient bit per clock for WIDTH clocks.
// The signed quotient is published on entry to DONE together with a
// one-cycle ready pulse. A zero divisor skips the loop and reports the
// exception directly.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      div_unit_if slave (operands, start, result, flags)
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;        // |dividend|, shifted out MSB first
  logic [WIDTH-1:0] dvs_q, dvs_d;        // |divisor|
  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0] quot_q, quot_d;      // unsigned quotient being built
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_shift, quot_next;
  logic             fits;

  // Magnitudes are WIDTH-bit unsigned: -(0x80000000) wraps to 0x80000000,
  // which is the correct unsigned magnitude.
  assign abs_a = bus.data_operandA[WIDTH-1] ? ('0 - bus.data_operandA) : bus.data_operandA;
  assign abs_b = bus.data_operandB[WIDTH-1] ? ('0 - bus.data_operandB) : bus.data_operandB;

  // The remainder always stays below |B| <= 2^(WIDTH-1), so its MSB is zero
  // and dropping it in the shift loses nothing.
  assign rem_shift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign fits      = (rem_shift >= dvs_q);
  assign quot_next = {quot_q[WIDTH-2:0], fits};

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch so the
    // block stays purely combinational; a missed path would infer a latch.
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    exc_d    = exc_q;

    // A start is honoured in every state: from IDLE it begins, from CALC it
    // aborts and restarts, from DONE it overlaps the ready pulse.
    if (bus.ctrl_DIV) begin
      dvd_d  = abs_a;
      dvs_d  = abs_b;
      sign_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      rem_d  = '0;
      quot_d = '0;
      cnt_d  = '0;
      if (bus.data_operandB == '0) begin
        state_d  = DONE;
        result_d = '0;
        exc_d    = 1'b1;
      end else begin
        state_d  = CALC;
      end
    end else begin
      unique case (state_q)
        CALC: begin
          rem_d  = fits ? (rem_shift - dvs_q) : rem_shift;
          quot_d = quot_next;
          dvd_d  = dvd_q << 1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = sign_q ? ('0 - quot_next) : quot_next;
            exc_d    = 1'b0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = (state_q == CALC);

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
//
// A behavioural model tracks, per clock edge, what the divider must present:
// a start computes the signed quotient with plain integer division and
// schedules it WIDTH edges later (or immediately for a zero divisor); a new
// start discards anything pending. A compare process checks every output on
// every falling edge. Directed cases pin the model with literal values, then
// a randomized phase issues sparse starts (including aborts, starts in the
// ready cycle, zero divisors and the overflow case).
// ---------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed quotient truncated toward zero, wrapped to W bits.
  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return '0;
    return W'(sa / sb);
  endfunction

  // ------------------------------------------------------------------ model
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pend   = '0;
  logic         m_exc    = 1'b0;
  logic         m_rdy    = 1'b0;
  int           m_left   = 0;   // edges until the pending quotient appears

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_result <= '0;
      m_pend   <= '0;
      m_exc    <= 1'b0;
      m_rdy    <= 1'b0;
      m_left   <= 0;
    end else if (bus.ctrl_DIV) begin
      if (bus.data_operandB == '0) begin
        m_left   <= 0;
        m_rdy    <= 1'b1;
        m_result <= '0;
        m_exc    <= 1'b1;
      end else begin
        m_left   <= W;
        m_rdy    <= 1'b0;
        m_pend   <= ref_quot(bus.data_operandA, bus.data_operandB);
      end
    end else if (m_left == 1) begin
      m_left   <= 0;
      m_rdy    <= 1'b1;
      m_result <= m_pend;
      m_exc    <= 1'b0;
    end else begin
      if (m_left > 0) m_left <= m_left - 1;
      m_rdy <= 1'b0;
    end
  end

  always @(negedge clock) begin
    check("rdy",    W'(bus.data_resultRDY), W'(m_rdy));
    check("busy",   W'(bus.busy),           W'(m_left != 0));
    check("result", bus.data_result,        m_result);
    check("exc",    W'(bus.data_exception), W'(m_exc));
  end

  // -------------------------------------------------------------- stimulus
  // Called just after a rising edge. Issues a one-cycle start, then waits
  // (bounded) for the ready pulse and checks literal expectations.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic exp_e, input int exp_edges);
    int edges;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;   // operands must only matter on the start edge
    bus.data_operandB = $urandom;
    edges = 0;
    while (!bus.data_resultRDY && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check({name, "_edges"},  W'(edges),               W'(exp_edges));
    check({name, "_result"}, bus.data_result,          exp_q);
    check({name, "_exc"},    W'(bus.data_exception),   W'(exp_e));
  endtask

  function automatic logic [W-1:0] pick_a();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return W'($urandom_range(0, 200));
      2:       return '0 - W'($urandom_range(0, 200));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] pick_b();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return W'($urandom_range(1, 20));
      3:       return '0 - W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    // Model pins: literal quotients from the arithmetic rules.
    check("model_neg_a",    ref_quot(32'hFFFF_FF9C, 32'd7),       32'hFFFF_FFF2);
    check("model_overflow", ref_quot(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    // Reset for 3 cycles, then idle.
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("idle_result", bus.data_result,         '0);
    check("idle_exc",    W'(bus.data_exception),  '0);
    check("idle_rdy",    W'(bus.data_resultRDY),  '0);
    check("idle_busy",   W'(bus.busy),            '0);

    run_op("pos", 32'd100, 32'd7, 32'd14, 1'b0, 32);
    repeat (10) @(posedge clock);
    #1 check("pos_held", bus.data_result, 32'd14);

    run_op("neg_a",   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 32);
    @(posedge clock); #1;
    run_op("neg_b",   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 32);
    @(posedge clock); #1;
    run_op("neg_ab",  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0, 32);
    @(posedge clock); #1;
    run_op("small",   32'd6,         32'd7,         32'd0,         1'b0, 32);
    @(posedge clock); #1;
    run_op("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32);
    @(posedge clock); #1;

    // Divide by zero reports on the edge that accepts the start.
    run_op("dz",      32'd5, 32'd0, 32'd0, 1'b1, 0);
    @(posedge clock); #1;
    run_op("after_dz", 32'd9, 32'd3, 32'd3, 1'b0, 32);

    // Start issued in the ready cycle itself.
    run_op("in_done", 32'd77, 32'd11, 32'd7, 1'b0, 32);
    @(posedge clock); #1;

    // Restart mid-calculation: only the second operation completes.
    bus.data_operandA = 32'd1000;
    bus.data_operandB = 32'd10;
    bus.ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1 bus.ctrl_DIV   = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    run_op("restart", 32'd50, 32'd5, 32'd10, 1'b0, 32);
    @(posedge clock); #1;

    // Asynchronous reset in the middle of an operation.
    bus.data_operandA = 32'd81;
    bus.data_operandB = 32'd9;
    bus.ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1 bus.ctrl_DIV   = 1'b0;
    repeat (15) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_busy",   W'(bus.busy),            '0);
    check("rst_result", bus.data_result,         '0);
    check("rst_rdy",    W'(bus.data_resultRDY),  '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    run_op("post_rst", 32'd81, 32'd9, 32'd9, 1'b0, 32);

    // Randomized sparse starts; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock);
      #1;
      if ($urandom_range(0, 29) == 0) begin
        bus.data_operandA = pick_a();
        bus.data_operandB = pick_b();
        bus.ctrl_DIV      = 1'b1;
      end else begin
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
      end
    end
    bus.ctrl_DIV = 1'b0;
    repeat (40) @(posedge clock);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
